seg7_monitor: RTL and testbench
===============================

SEG7_MONITOR -- requirements
Module: seg7_monitor

Interface
REQ-001 SHALL have parameter BW, default 3, width of counter_val_i (legal 1..4).
REQ-002 SHALL have parameter DIV, default 4, clock cycles per sample tick (legal 2..255).
REQ-003 SHALL have parameter HOLD, default 8, cycles dp_o stays high after a wrap (legal 1..255).
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port counter_val_i  input  BW  value from the upstream counter's counter_val_o.
REQ-007 SHALL have port enable_i  input  1  1 = sample and track; 0 = freeze the displayed value.
REQ-008 SHALL have port seg_o  output  7  segments {g,f,e,d,c,b,a}, active high, registered.
REQ-009 SHALL have port dp_o  output  1  decimal point, high while a wrap indication is active, registered.

Function
REQ-010 SHALL run a prescaler counting 0..DIV-1 and wrapping to 0; tick is true in the cycle the prescaler equals DIV-1; the prescaler runs regardless of enable_i.
REQ-011 SHALL implement FSM states BLANK, SHOW and HOLD; reset state BLANK.
REQ-012 SHALL transition BLANK->SHOW on the first tick with enable_i=1; SHOW->HOLD when enable_i=0; HOLD->SHOW when enable_i=1; BLANK stays BLANK while enable_i=0.
REQ-013 SHALL capture counter_val_i, zero-extended to 4 bits, into sample register val_q at the edge ending a tick cycle only when enable_i=1; no capture otherwise.
REQ-014 SHALL flag a wrap when a capture occurs in SHOW and the new value is numerically less than val_q; the first capture out of BLANK never flags a wrap.
REQ-015 SHALL load a hold counter with HOLD at the edge of a wrap capture; the counter decrements by one each cycle while nonzero; a new wrap reloads it to HOLD, and reload wins over a decrement in the same cycle.
REQ-016 SHALL drive seg_o with the hex decode (0-F) of val_q one clock after val_q changes; in BLANK, seg_o SHALL be 7'h00.
REQ-017 SHALL use decode values 0=7'h3F, 1=7'h06, 2=7'h5B, 3=7'h4F, 4=7'h66, 5=7'h6D, 6=7'h7D, 7=7'h07, 8=7'h7F, 9=7'h6F, A=7'h77, b=7'h7C, C=7'h39, d=7'h5E, E=7'h79, F=7'h71.
REQ-018 SHALL drive dp_o high from the same edge that seg_o first shows the wrapped value, for exactly HOLD consecutive cycles when not retriggered.
REQ-019 SHALL leave an active dp_o hold running to completion on entry to HOLD.

Reset
REQ-020 SHALL, at any rising edge with rst_i=0, set prescaler=0, val_q=0, hold counter=0, state=BLANK, seg_o=7'h00, dp_o=0, including mid-hold or mid-prescale.
REQ-021 SHALL resume normal operation on the first edge with rst_i=1; the first tick occurs DIV cycles after reset release.

Configuration
REQ-022 SHALL compile the blink feature only when macro SEG7_MONITOR_BLINK_EN is defined.
REQ-023 SHALL, with SEG7_MONITOR_BLINK_EN defined, in HOLD toggle a blink flag on every tick and drive seg_o=7'h00 while the flag is set; the flag clears on reset and on leaving HOLD.
REQ-024 SHALL, without SEG7_MONITOR_BLINK_EN, show the decode of val_q steadily in HOLD; no blink logic is present.

Structure
REQ-025 SHALL place the FSM state encoding and the 16-entry segment decode constants in shared package seg7_pkg.
REQ-026 SHALL implement the hex-to-segment lookup as combinational sub-module seg7_decode (4-bit in, 7-bit out), instantiated once.

Verification
REQ-027 SHALL check reset: hold rst_i=0 for 5 cycles with counter_val_i=5 -> seg_o=7'h00, dp_o=0 throughout, and still 7'h00 for DIV-1 cycles after release.
REQ-028 SHALL check tracking: DIV=4, enable_i=1, counter_val_i=3 stable -> seg_o=7'h4F one clock after first capture, dp_o=0.
REQ-029 SHALL check wrap: BW=3, HOLD=8, capture 7 then 0 -> seg_o 7'h07 then 7'h3F; dp_o high exactly 8 cycles starting with 7'h3F.
REQ-030 SHALL check retrigger: two wraps 6 cycles apart with HOLD=8 -> dp_o high continuously for 6+8=14 cycles.
REQ-031 SHALL check freeze: enable_i=0 while showing 2, counter_val_i changes to 4 -> seg_o stays 7'h5B (blink build: alternates 7'h5B/7'h00 every DIV cycles); enable_i=1 -> 7'h66 after next capture.
REQ-032 SHALL check reset mid-hold: assert rst_i=0 three cycles into a dp_o hold -> dp_o=0, seg_o=7'h00 at that edge.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment counter monitor:
// FSM state encoding and the hex-to-segment lookup table.
package seg7_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned HEX_W = 4;

    typedef enum logic [1:0] {
        ST_BLANK = 2'd0,
        ST_SHOW  = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;

    // Segments {g,f,e,d,c,b,a}, active high; entry 15 is the leftmost element.
    localparam logic [15:0][SEG_W-1:0] SEG_LUT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex digit to seven-segment pattern lookup.
// Ports: hex_i  - 4-bit digit
//        seg_c  - segments {g,f,e,d,c,b,a}, active high (combinational)
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [HEX_W-1:0] hex_i,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = SEG_LUT[hex_i];
    end

endmodule

// File: rtl/seg7_monitor.sv
// Samples an upstream counter on a prescaled tick, shows it on a
// seven-segment display and lights the decimal point for HOLD cycles
// whenever the sampled value wraps (goes numerically down).
// Optional build macro SEG7_MONITOR_BLINK_EN: display blinks while frozen.
// Ports: clk_i          - clock, rising edge
//        rst_i          - synchronous reset, active low
//        counter_val_i  - upstream counter value (BW bits)
//        enable_i       - 1 = sample and track, 0 = freeze display
//        seg_o          - registered segments {g,f,e,d,c,b,a}
//        dp_o           - registered decimal point, wrap indication
module seg7_monitor
    import seg7_pkg::*;
#(
    parameter int unsigned BW   = 3,
    parameter int unsigned DIV  = 4,
    parameter int unsigned HOLD = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [BW-1:0]     counter_val_i,
    input  logic              enable_i,
    output logic [SEG_W-1:0]  seg_o,
    output logic              dp_o
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned HW = $clog2(HOLD + 1);

    logic [PW-1:0]    pre_q, pre_d;
    logic [HEX_W-1:0] val_q, val_d;
    logic [HW-1:0]    hold_q, hold_d;
    state_e           state_q, state_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             tick_c;
    logic             capture_c;
    logic             wrap_c;
    logic [HEX_W-1:0] val_ext_c;
    logic [SEG_W-1:0] dec_seg_c;
`ifdef SEG7_MONITOR_BLINK_EN
    logic             blink_q, blink_d;
`endif

    seg7_decode u_decode (
        .hex_i (val_q),
        .seg_c (dec_seg_c)
    );

    // Next-state and output logic
    always_comb begin
        pre_d     = pre_q;
        val_d     = val_q;
        hold_d    = hold_q;
        state_d   = state_q;
        seg_d     = SEG_OFF;
        dp_d      = 1'b0;
        tick_c    = (pre_q == PW'(DIV - 1));
        capture_c = tick_c && enable_i;
        val_ext_c = HEX_W'(counter_val_i);
        // The first capture out of BLANK never counts as a wrap.
        wrap_c    = capture_c && (state_q == ST_SHOW) && (val_ext_c < val_q);

        pre_d = tick_c ? '0 : pre_q + PW'(1);

        if (capture_c) begin
            val_d = val_ext_c;
        end

        // Reload has priority over the running decrement.
        if (wrap_c) begin
            hold_d = HW'(HOLD);
        end else if (hold_q != '0) begin
            hold_d = hold_q - HW'(1);
        end

        case (state_q)
            ST_BLANK: if (capture_c) state_d = ST_SHOW;
            ST_SHOW:  if (!enable_i) state_d = ST_HOLD;
            ST_HOLD:  if (enable_i)  state_d = ST_SHOW;
            default:  state_d = ST_BLANK;
        endcase

        if (state_q != ST_BLANK) begin
            seg_d = dec_seg_c;
        end

`ifdef SEG7_MONITOR_BLINK_EN
        blink_d = blink_q;
        if (state_d != ST_HOLD) begin
            blink_d = 1'b0;
        end else if ((state_q == ST_HOLD) && tick_c) begin
            blink_d = ~blink_q;
        end
        if ((state_q == ST_HOLD) && blink_q) begin
            seg_d = SEG_OFF;
        end
`endif

        dp_d = (hold_q != '0);
    end

    // State registers
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            pre_q   <= '0;
            val_q   <= '0;
            hold_q  <= '0;
            state_q <= ST_BLANK;
            seg_q   <= SEG_OFF;
            dp_q    <= 1'b0;
`ifdef SEG7_MONITOR_BLINK_EN
            blink_q <= 1'b0;
`endif
        end else begin
            pre_q   <= pre_d;
            val_q   <= val_d;
            hold_q  <= hold_d;
            state_q <= state_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
`ifdef SEG7_MONITOR_BLINK_EN
            blink_q <= blink_d;
`endif
        end
    end

    assign seg_o = seg_q;
    assign dp_o  = dp_q;

endmodule

// File: tb/tb_seg7_monitor.sv
// Directed bench for seg7_monitor: a default instance (DIV=4, HOLD=8)
// and a DIV=3 instance for wraps spaced 6 cycles apart.
// k counts rising edges since the last edge that sampled reset low.
module tb_seg7_monitor;

    logic       clk;
    logic       rst;
    logic [2:0] val1, val2;
    logic       en1, en2;
    logic [6:0] seg1, seg2;
    logic       dp1, dp2;

    int n_tests = 0;
    int n_fail  = 0;
    int k       = 0;

    seg7_monitor #(.BW(3), .DIV(4), .HOLD(8)) u_dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .counter_val_i (val1),
        .enable_i      (en1),
        .seg_o         (seg1),
        .dp_o          (dp1)
    );

    seg7_monitor #(.BW(3), .DIV(3), .HOLD(8)) u_dut3 (
        .clk_i         (clk),
        .rst_i         (rst),
        .counter_val_i (val2),
        .enable_i      (en2),
        .seg_o         (seg2),
        .dp_o          (dp2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        k = 0;
    endtask

    task automatic test_reset();
        val1 = 3'd5;
        en1  = 1'b1;
        rst  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_tests++;
            if (seg1 !== 7'h00) begin
                n_fail++;
                $display("FAIL reset_seg cycle %0d: got %h want 00", i, seg1);
            end
            n_tests++;
            if (dp1 !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_dp cycle %0d: got %b want 0", i, dp1);
            end
        end
        rst = 1'b1;
        k = 0;
        while (k < 4) begin
            step();
            n_tests++;
            if (seg1 !== 7'h00) begin
                n_fail++;
                $display("FAIL release_seg k=%0d: got %h want 00", k, seg1);
            end
        end
        step();
        n_tests++;
        if (seg1 !== 7'h6D) begin
            n_fail++;
            $display("FAIL first_tick_seg k=%0d: got %h want 6d", k, seg1);
        end
    endtask

    task automatic test_track();
        val1 = 3'd3;
        en1  = 1'b1;
        do_reset();
        repeat (4) step();
        n_tests++;
        if (seg1 !== 7'h00) begin
            n_fail++;
            $display("FAIL track_pre_seg: got %h want 00", seg1);
        end
        step();
        n_tests++;
        if (seg1 !== 7'h4F) begin
            n_fail++;
            $display("FAIL track_seg: got %h want 4f", seg1);
        end
        n_tests++;
        if (dp1 !== 1'b0) begin
            n_fail++;
            $display("FAIL track_dp: got %b want 0", dp1);
        end
    endtask

    task automatic test_wrap();
        logic [6:0] exp_seg;
        logic       exp_dp;
        int         high_cnt;
        high_cnt = 0;
        val1 = 3'd7;
        en1  = 1'b1;
        do_reset();
        repeat (4) step();
        while (k < 17) begin
            step();
            exp_seg = (k <= 8) ? 7'h07 : 7'h3F;
            exp_dp  = (k >= 9) && (k <= 16);
            if (dp1 === 1'b1) high_cnt++;
            n_tests++;
            if (seg1 !== exp_seg) begin
                n_fail++;
                $display("FAIL wrap_seg k=%0d: got %h want %h", k, seg1, exp_seg);
            end
            n_tests++;
            if (dp1 !== exp_dp) begin
                n_fail++;
                $display("FAIL wrap_dp k=%0d: got %b want %b", k, dp1, exp_dp);
            end
            if (k == 5) val1 = 3'd0;
        end
        n_tests++;
        if (high_cnt != 8) begin
            n_fail++;
            $display("FAIL wrap_dp_len: got %0d want 8", high_cnt);
        end
    endtask

    task automatic test_retrigger();
        logic exp_dp;
        int   high_cnt;
        high_cnt = 0;
        en1  = 1'b0;
        val2 = 3'd5;
        en2  = 1'b1;
        do_reset();
        while (k < 21) begin
            step();
            if (k >= 6) begin
                exp_dp = (k >= 7) && (k <= 20);
                if (dp2 === 1'b1) high_cnt++;
                n_tests++;
                if (dp2 !== exp_dp) begin
                    n_fail++;
                    $display("FAIL retrig_dp k=%0d: got %b want %b", k, dp2, exp_dp);
                end
            end
            if (k == 4) begin
                n_tests++;
                if (seg2 !== 7'h6D) begin
                    n_fail++;
                    $display("FAIL retrig_seg5: got %h want 6d", seg2);
                end
            end
            if (k == 13) begin
                n_tests++;
                if (seg2 !== 7'h5B) begin
                    n_fail++;
                    $display("FAIL retrig_seg2: got %h want 5b", seg2);
                end
            end
            if (k == 3) val2 = 3'd1;
            if (k == 6) val2 = 3'd6;
            if (k == 9) val2 = 3'd2;
        end
        n_tests++;
        if (high_cnt != 14) begin
            n_fail++;
            $display("FAIL retrig_dp_len: got %0d want 14", high_cnt);
        end
        en2 = 1'b0;
    endtask

    task automatic test_freeze();
        logic [6:0] exp_seg;
        val1 = 3'd2;
        en1  = 1'b1;
        do_reset();
        repeat (4) step();
        while (k < 17) begin
            step();
            exp_seg = 7'h5B;
`ifdef SEG7_MONITOR_BLINK_EN
            if ((k >= 9) && (k <= 12)) exp_seg = 7'h00;
`endif
            if (k == 17) exp_seg = 7'h66;
            n_tests++;
            if (seg1 !== exp_seg) begin
                n_fail++;
                $display("FAIL freeze_seg k=%0d: got %h want %h", k, seg1, exp_seg);
            end
            n_tests++;
            if (dp1 !== 1'b0) begin
                n_fail++;
                $display("FAIL freeze_dp k=%0d: got %b want 0", k, dp1);
            end
            if (k == 5) begin
                en1  = 1'b0;
                val1 = 3'd4;
            end
            if (k == 14) en1 = 1'b1;
        end
    endtask

    task automatic test_reset_midhold();
        val1 = 3'd7;
        en1  = 1'b1;
        do_reset();
        while (k < 11) begin
            step();
            if (k == 5) val1 = 3'd0;
        end
        n_tests++;
        if (dp1 !== 1'b1) begin
            n_fail++;
            $display("FAIL midhold_pre_dp: got %b want 1", dp1);
        end
        rst = 1'b0;
        step();
        n_tests++;
        if (dp1 !== 1'b0) begin
            n_fail++;
            $display("FAIL midhold_rst_dp: got %b want 0", dp1);
        end
        n_tests++;
        if (seg1 !== 7'h00) begin
            n_fail++;
            $display("FAIL midhold_rst_seg: got %h want 00", seg1);
        end
        rst = 1'b1;
        k = 0;
        while (k < 6) begin
            step();
            n_tests++;
            if (dp1 !== 1'b0) begin
                n_fail++;
                $display("FAIL after_rst_dp k=%0d: got %b want 0", k, dp1);
            end
        end
        n_tests++;
        if (seg1 !== 7'h3F) begin
            n_fail++;
            $display("FAIL after_rst_seg: got %h want 3f", seg1);
        end
    endtask

    initial begin
        rst  = 1'b0;
        val1 = 3'd0;
        val2 = 3'd0;
        en1  = 1'b0;
        en2  = 1'b0;
        test_reset();
        test_track();
        test_wrap();
        test_retrigger();
        test_freeze();
        test_reset_midhold();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
